// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-organised data memory slave with programmable wait states. A legal
//   request is latched in IDLE; after WAIT_CYCLES edges the access happens
//   and Ready pulses for one cycle. Illegal requests (read+write together,
//   misaligned, or beyond DEPTH) produce a one-cycle Error pulse instead.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for a request, sampling legality every edge
//   WAIT    | request latched, counting down the wait states
//   RESPOND | access done, Ready high this cycle, back to IDLE next
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   Address    byte address, word index = Address[31:2]
//   MemRead    read request
//   MemWrite   write request
//   WriteData  store data
//   ReadData   registered load data, holds until the next completed read
//   Ready      registered one-cycle completion pulse
//   Error      registered one-cycle rejection pulse
//   Busy       combinational, high whenever state is not IDLE
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Error,
  output logic        Busy
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  localparam logic [3:0]  WAIT_W  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESPOND} state_t;

  state_t             state, state_next;
  logic [3:0]         cnt, cnt_next;
  logic               op_write;
  logic [IDX_W-1:0]   op_idx;
  logic [31:0]        op_wdata;
  logic [31:0]        mem [DEPTH];

  logic               req, illegal;
  logic               accept, access, err_set;
  logic               acc_write;
  logic [IDX_W-1:0]   acc_idx;
  logic [31:0]        acc_wdata;

  assign req     = MemRead | MemWrite;
  // Upper address bits take part in the range check, so nothing wraps.
  assign illegal = (MemRead & MemWrite) | (Address[1:0] != 2'b00) |
                   (Address[31:2] >= DEPTH_W);

  // With zero wait states the access happens at the accepting edge, so the
  // operands come straight from the inputs instead of the latched copy.
  assign acc_write = (state == ST_IDLE) ? MemWrite               : op_write;
  assign acc_idx   = (state == ST_IDLE) ? Address[IDX_W+1:2]     : op_idx;
  assign acc_wdata = (state == ST_IDLE) ? WriteData              : op_wdata;

  assign Busy = (state != ST_IDLE);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    access     = 1'b0;
    err_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (illegal) begin
            err_set = 1'b1;
          end else begin
            accept = 1'b1;
            if (WAIT_W == 4'd0) begin
              state_next = ST_RESPOND;
              access     = 1'b1;
            end else begin
              state_next = ST_WAIT;
              cnt_next   = WAIT_W;
            end
          end
        end
      end
      ST_WAIT: begin
        if (cnt > 4'd1) begin
          cnt_next = cnt - 4'd1;
        end else begin
          cnt_next   = 4'd0;
          state_next = ST_RESPOND;
          access     = 1'b1;
        end
      end
      ST_RESPOND: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      op_write <= 1'b0;
      op_idx   <= '0;
      op_wdata <= 32'd0;
      ReadData <= 32'd0;
      Ready    <= 1'b0;
      Error    <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      Ready <= access;
      Error <= err_set;
      if (accept) begin
        op_write <= MemWrite;
        op_idx   <= Address[IDX_W+1:2];
        op_wdata <= WriteData;
      end
      if (access && !acc_write) begin
        ReadData <= mem[acc_idx];
      end
    end
  end

  // Array is never cleared; reset only blocks a write at a coincident edge.
  always_ff @(posedge clk) begin
    if (access && acc_write && !reset) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder. Two instances run side by side,
// one with two wait states and one with none. A transaction-level model at
// each rising edge decides whether a request is accepted or rejected and
// pushes the expected Ready/Error event; a monitor on the falling edge pops
// and compares Ready, Error, Busy and ReadData.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd   [2];
  logic        wr   [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic        rdy  [2];
  logic        err  [2];
  logic        bsy  [2];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .reset(rst), .Address(addr[0]), .MemRead(rd[0]),
    .MemWrite(wr[0]), .WriteData(wdat[0]), .ReadData(rdat[0]),
    .Ready(rdy[0]), .Error(err[0]), .Busy(bsy[0])
  );

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(rst), .Address(addr[1]), .MemRead(rd[1]),
    .MemWrite(wr[1]), .WriteData(wdat[1]), .ReadData(rdat[1]),
    .Ready(rdy[1]), .Error(err[1]), .Busy(bsy[1])
  );

  typedef struct {
    int          inst;
    int          due;
    bit          is_err;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];

  logic [31:0] mm [2][256];
  bit          mv [2][256];
  int          m_free     [2];
  int          busy_until [2];
  bit          pend       [2];
  int          pend_edge  [2];
  int          pend_idx   [2];
  logic [31:0] pend_data  [2];
  logic [31:0] m_last     [2];
  bit          m_lastk    [2];

  function automatic int wc(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int first_of(int i);
    foreach (sb[k]) if (sb[k].inst == i) return k;
    return -1;
  endfunction

  task automatic chk(string nm, int i, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", nm, i, cyc, got, want);
    end
  endtask

  // Reference model: transaction timing from the accept edge n.
  //   Ready/ReadData in the cycle after edge n+W, Busy after edges n..n+W,
  //   next request can be taken at edge n+W+2. Rejects show after edge n.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      sb.delete();
      for (int i = 0; i < 2; i++) begin
        m_free[i]     = 0;
        busy_until[i] = -1;
        pend[i]       = 1'b0;
        m_last[i]     = 32'd0;
        m_lastk[i]    = 1'b1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if ((rd[i] || wr[i]) && cyc >= m_free[i]) begin
          if ((rd[i] && wr[i]) || addr[i][1:0] != 2'b00 || addr[i][31:2] >= 30'd256) begin
            sb.push_back('{inst:i, due:cyc, is_err:1'b1, chk:1'b0, data:32'd0});
          end else begin
            int idx;
            idx = int'(addr[i][31:2]);
            if (wr[i]) begin
              pend[i]      = 1'b1;
              pend_edge[i] = cyc + wc(i);
              pend_idx[i]  = idx;
              pend_data[i] = wdat[i];
              sb.push_back('{inst:i, due:cyc + wc(i), is_err:1'b0, chk:m_lastk[i], data:m_last[i]});
            end else begin
              m_last[i]  = mm[i][idx];
              m_lastk[i] = mv[i][idx];
              sb.push_back('{inst:i, due:cyc + wc(i), is_err:1'b0, chk:m_lastk[i], data:m_last[i]});
            end
            m_free[i]     = cyc + wc(i) + 2;
            busy_until[i] = cyc + wc(i);
          end
        end
        if (pend[i] && cyc == pend_edge[i]) begin
          mm[i][pend_idx[i]] = pend_data[i];
          mv[i][pend_idx[i]] = 1'b1;
          pend[i]            = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        int k;
        bit exp_r, exp_e;
        k     = first_of(i);
        exp_r = (k >= 0) && sb[k].due == cyc && !sb[k].is_err;
        exp_e = (k >= 0) && sb[k].due == cyc &&  sb[k].is_err;
        chk("ready", i, {31'd0, rdy[i]}, {31'd0, exp_r});
        chk("error", i, {31'd0, err[i]}, {31'd0, exp_e});
        chk("busy",  i, {31'd0, bsy[i]}, {31'd0, (cyc <= busy_until[i])});
        if (exp_r && sb[k].chk) chk("rdata", i, rdat[i], sb[k].data);
        if (exp_r || exp_e) sb.delete(k);
      end
    end
  end

  task automatic hold(int i, bit r, bit w, logic [31:0] a, logic [31:0] d, int n);
    rd[i] = r; wr[i] = w; addr[i] = a; wdat[i] = d;
    repeat (n) @(negedge clk);
    #1;
    rd[i] = 1'b0; wr[i] = 1'b0;
  endtask

  task automatic gap(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic xact(int i, bit r, bit w, logic [31:0] a, logic [31:0] d);
    hold(i, r, w, a, d, 1);
    gap(wc(i) + 2);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'd0; wdat[i] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", i, {31'd0, rdy[i]}, 32'd0);
      chk("rst_error", i, {31'd0, err[i]}, 32'd0);
      chk("rst_busy",  i, {31'd0, bsy[i]}, 32'd0);
      chk("rst_rdata", i, rdat[i], 32'd0);
    end
    #1 rst = 1'b0;

    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 16; k++) xact(i, 1'b0, 1'b1, k * 4, $urandom);

    // two wait states: write then read back
    xact(0, 1'b0, 1'b1, 32'h4, 32'h12345678);
    xact(0, 1'b1, 1'b0, 32'h4, 32'd0);
    // illegal requests, each held three cycles, then mem[0] untouched
    hold(0, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, 3);
    hold(0, 1'b1, 1'b0, 32'h6, 32'd0, 3);
    hold(0, 1'b1, 1'b0, 32'h400, 32'd0, 3);
    hold(0, 1'b0, 1'b1, 32'h8000_0000, 32'd7, 3);
    gap(1);
    xact(0, 1'b1, 1'b0, 32'h0, 32'd0);
    // request dropped and inputs toggled during WAIT
    hold(0, 1'b0, 1'b1, 32'hC, 32'h1, 1);
    hold(0, 1'b1, 1'b0, $urandom, 32'd0, 2);
    gap(3);
    xact(0, 1'b1, 1'b0, 32'hC, 32'd0);
    // back-to-back read held continuously
    hold(0, 1'b1, 1'b0, 32'h4, 32'd0, 13);
    gap(4);
    // zero wait states
    xact(1, 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5);
    xact(1, 1'b1, 1'b0, 32'h8, 32'd0);
    hold(1, 1'b1, 1'b0, 32'h4, 32'd0, 6);
    hold(1, 1'b1, 1'b1, 32'h0, 32'd0, 3);
    gap(2);
    // reset one cycle after a write was accepted
    hold(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy",  0, {31'd0, bsy[0]}, 32'd0);
    chk("rst_mid_ready", 0, {31'd0, rdy[0]}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    gap(2);
    xact(0, 1'b1, 1'b0, 32'h10, 32'd0);

    repeat (120) begin
      for (int i = 0; i < 2; i++) begin
        int kind;
        logic [31:0] a;
        kind = $urandom_range(0, 9);
        a    = 32'($urandom_range(0, 15)) * 4;
        if (kind < 6) begin
          bit w;
          w = 1'($urandom_range(0, 1));
          hold(i, !w, w, a, $urandom, $urandom_range(1, 3));
        end else if (kind == 6) begin
          hold(i, 1'b1, 1'b1, a, $urandom, $urandom_range(1, 3));
        end else if (kind == 7) begin
          hold(i, 1'b1, 1'b0, a + 32'($urandom_range(1, 3)), 32'd0, $urandom_range(1, 3));
        end else if (kind == 8) begin
          a = $urandom;
          a[1:0] = 2'b00;
          a[10]  = 1'b1;
          hold(i, 1'($urandom_range(0, 1)), 1'b1, a, $urandom, $urandom_range(1, 3));
        end else begin
          gap(1);
        end
        gap($urandom_range(0, 4));
      end
    end

    gap(6);
    for (int i = 0; i < 2; i++) begin
      int left;
      left = 0;
      foreach (sb[k]) if (sb[k].inst == i) left++;
      chk("drain", i, 32'(left), 32'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Word-organised data memory slave that answers the CPU's MemRead/MemWrite requests.
- Inserts a programmable number of wait states and signals completion with a one-cycle Ready pulse.
- Replaces the zero-latency data memory in the datapath, so the CPU (or a future stall unit) can be exercised against realistic memory timing.
- Rejects illegal requests (simultaneous read+write, misaligned, out of range) with an Error pulse.

Parameters:
- DEPTH, 256, number of 32-bit words; word index = Address[31:2].
- WAIT_CYCLES, 2, wait states between acceptance and response; legal range 0..15.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- Address  input  32  byte address from the ALU result
- MemRead  input  1  read request
- MemWrite  input  1  write request
- WriteData  input  32  store data
- ReadData  output  32  load data, registered
- Ready  output  1  transaction complete, registered one-cycle pulse
- Error  output  1  request rejected, registered one-cycle pulse
- Busy  output  1  combinational, high when state is not IDLE

Behaviour:
- Reset (async, any state):
  - state=IDLE, Ready=0, Error=0, ReadData=0, wait counter=0.
  - Any latched transaction is discarded.
  - Memory array contents are not cleared and are not modified by reset.
- States: IDLE, WAIT, RESPOND.
- IDLE, at a rising edge:
  - MemRead=MemWrite=0: stay IDLE.
  - MemRead=MemWrite=1, or Address[1:0]!=0, or Address[31:2]>=DEPTH: Error=1 for the next cycle, stay IDLE, no memory access.
  - Legal request: latch op, Address[31:2] and WriteData.
    - WAIT_CYCLES=0: go directly to RESPOND and perform the access at this same edge.
    - Otherwise: go to WAIT with counter=WAIT_CYCLES.
- WAIT, at each edge:
  - counter>1: decrement, stay WAIT.
  - counter==1: go RESPOND and perform the access at this edge.
- Access (at the edge that enters RESPOND):
  - Write: mem[index]<=latched WriteData. ReadData unchanged.
  - Read: ReadData<=mem[index].
  - Ready<=1.
- RESPOND, at the next edge: Ready<=0, go IDLE.
- Latency: request accepted at edge N; Ready is high during the cycle following edge N+WAIT_CYCLES.
- Request inputs are ignored while in WAIT and RESPOND. The latched operation completes even if the initiator drops its request.
- The initiator deasserts its request in the Ready cycle. A request still asserted in the following IDLE cycle is a new transaction.
- Held illegal request: Error re-asserts every cycle it is sampled in IDLE.
- ReadData holds its value until the next completed read or reset.
- Ready and Error are never high in the same cycle.
- Read-after-write to the same word returns the new data, since the write committed at an earlier edge.
- Address bits above the index range are checked against DEPTH. No wrap-around.

Test Plan:
- Reset mid-WAIT: write 0xDEADBEEF to 0x10 with WAIT_CYCLES=2, assert reset one cycle after acceptance -> Ready never pulses, Busy=0, a later read of 0x10 returns the prior contents.
- Write 0x12345678 to 0x04, then read 0x04 (WAIT_CYCLES=2) -> Ready pulses exactly 2 edges after each acceptance; ReadData=0x12345678 in the read's Ready cycle; Busy high for 3 cycles per transaction.
- WAIT_CYCLES=0: read 0x08 after writing 0xA5A5A5A5 -> Ready high the cycle immediately after the accepting edge, ReadData=0xA5A5A5A5.
- Illegal requests:
  - MemRead=MemWrite=1 at 0x0 -> Error=1, Ready=0, mem[0] unchanged.
  - Address=0x6 -> Error=1.
  - Address=4*DEPTH (0x400) -> Error=1.
  - Each illegal request held for 3 cycles -> Error high 3 consecutive cycles.
- Request dropped during WAIT: issue a write of 0x1 to 0xC, deassert MemWrite one cycle later -> write still commits, Ready still pulses on schedule; toggling MemRead/Address during WAIT causes no extra transaction.
- Back-to-back: keep MemRead=1 at 0x4 continuously -> a new transaction is accepted in the IDLE cycle after each Ready; the Ready period is WAIT_CYCLES+2 cycles.
